// File: rtl/nd_2to1.sv
// nd_2to1: two-input merge stage feeding nd_1to2.
//
// Accepts messages on two 4-phase req/ack input channels (rcv0, rcv1),
// arbitrates between them round-robin, buffers accepted messages in a FIFO
// of FSZ entries and presents them in grant order on the 4-phase output
// channel snd0.
//
// Ports:
//   i_clk            single clock, all state changes on its rising edge
//   reset            asynchronous, active-low reset (0 = in reset)
//   ready            1 from the first rising edge after reset release
//   rcvN_req/ack     input channel N handshake (N = 0,1)
//   rcvN_src/dst     input channel N addresses (ASZ bits each)
//   rcvN_dat/red     input channel N data (DSZ) and redundancy (RSZ)
//   snd0_req/ack     output channel handshake
//   snd0_src/dst     output addresses (ASZ bits each)
//   snd0_dat/red     output data (DSZ) and redundancy (RSZ)
//   fifo_cnt         current FIFO occupancy, 0..FSZ

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

module nd_2to1 #(
  parameter int FSZ = 4,
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
) (
  input  logic                   i_clk,
  input  logic                   reset,
  output logic                   ready,

  input  logic                   rcv0_req,
  output logic                   rcv0_ack,
  input  logic [ASZ-1:0]         rcv0_src,
  input  logic [ASZ-1:0]         rcv0_dst,
  input  logic [DSZ-1:0]         rcv0_dat,
  input  logic [RSZ-1:0]         rcv0_red,

  input  logic                   rcv1_req,
  output logic                   rcv1_ack,
  input  logic [ASZ-1:0]         rcv1_src,
  input  logic [ASZ-1:0]         rcv1_dst,
  input  logic [DSZ-1:0]         rcv1_dat,
  input  logic [RSZ-1:0]         rcv1_red,

  output logic                   snd0_req,
  input  logic                   snd0_ack,
  output logic [ASZ-1:0]         snd0_src,
  output logic [ASZ-1:0]         snd0_dst,
  output logic [DSZ-1:0]         snd0_dat,
  output logic [RSZ-1:0]         snd0_red,

  output logic [$clog2(FSZ):0]   fifo_cnt
);

  localparam int AW = $clog2(FSZ);
  localparam int CW = AW + 1;
  localparam int MW = 2*ASZ + DSZ + RSZ;
  localparam logic [CW-1:0] FULL_CNT = CW'(FSZ);

  // Which input wins when both are eligible in the same cycle.
  typedef enum logic {
    FAV_RCV0 = 1'b0,
    FAV_RCV1 = 1'b1
  } fav_t;

  logic [MW-1:0] mem [FSZ];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  fav_t          fav;
  fav_t          fav_next;

  logic          not_full;
  logic          elig0;
  logic          elig1;
  logic          grant0;
  logic          grant1;
  logic          push;
  logic          pop;
  logic [MW-1:0] push_word;
  logic [MW-1:0] head_word;
  logic [CW-1:0] cnt_next;

  // Arbitration and FIFO control. The full test uses the occupancy before
  // the edge, so a same-edge pop never makes room for a push.
  always_comb begin
    not_full  = fifo_cnt < FULL_CNT;
    elig0     = ready & rcv0_req & ~rcv0_ack & not_full;
    elig1     = ready & rcv1_req & ~rcv1_ack & not_full;
    grant0    = elig0 & (~elig1 | (fav == FAV_RCV0));
    grant1    = elig1 & (~elig0 | (fav == FAV_RCV1));
    push      = grant0 | grant1;
    pop       = ready & ~snd0_req & ~snd0_ack & (fifo_cnt != '0);
    push_word = grant1 ? {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red}
                       : {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
    head_word = mem[rd_ptr];

    fav_next = fav;
    if (grant0) begin
      fav_next = FAV_RCV1;
    end else if (grant1) begin
      fav_next = FAV_RCV0;
    end

    cnt_next = fifo_cnt;
    if (push && !pop) begin
      cnt_next = fifo_cnt + CW'(1);
    end else if (pop && !push) begin
      cnt_next = fifo_cnt - CW'(1);
    end
  end

  // Message storage; contents are only meaningful between pointers, so no
  // reset is needed here.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Handshake, pointer and output-register state. Pointers wrap naturally
  // because FSZ is a power of two.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      ready    <= 1'b0;
      rcv0_ack <= 1'b0;
      rcv1_ack <= 1'b0;
      snd0_req <= 1'b0;
      snd0_src <= '0;
      snd0_dst <= '0;
      snd0_dat <= '0;
      snd0_red <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      fav      <= FAV_RCV0;
    end else begin
      ready    <= 1'b1;
      fav      <= fav_next;
      fifo_cnt <= cnt_next;

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      if (grant0) begin
        rcv0_ack <= 1'b1;
      end else if (!rcv0_req && rcv0_ack) begin
        rcv0_ack <= 1'b0;
      end

      if (grant1) begin
        rcv1_ack <= 1'b1;
      end else if (!rcv1_req && rcv1_ack) begin
        rcv1_ack <= 1'b0;
      end

      // Output fields are only reloaded on a pop, which keeps them stable
      // for the whole time snd0_req is high.
      if (pop) begin
        {snd0_src, snd0_dst, snd0_dat, snd0_red} <= head_word;
        snd0_req <= 1'b1;
      end else if (snd0_req && snd0_ack) begin
        snd0_req <= 1'b0;
      end
    end
  end

endmodule
